control_unit: RTL and testbench

Multi-cycle sequencer for the Mini SRC CPU; drives every datapath control strobe that the bench currently toggles by hand. It sits beside `datapath` and reads the instruction register and the CON flag. It produces the datapath's Moore-style, one-state-per-clock control word for fetch and for each supported instruction. Conditional branches are completed by gating PCin with CON.

---
 rtl/cpu_ctrl_pkg.sv | 84 ++++++++
 rtl/control_unit_if.sv | 27 ++
 rtl/op_class_decode.sv | 46 ++++
 rtl/control_unit.sv | 165 ++++++++++++++++
 tb/tb_control_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the Mini SRC control unit: opcodes, ALU functions,
// sequencer states, instruction classes and the datapath control word.
package cpu_ctrl_pkg;

   localparam int unsigned IR_W       = 32;
   localparam int unsigned OPCODE_W   = 5;
   localparam int unsigned ALUOP_W    = 4;
   localparam int unsigned OPCODE_LSB = 27;

   localparam logic [OPCODE_W-1:0] OP_LD   = 5'd0;
   localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd1;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'd2;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd3;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd4;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'd5;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'd6;
   localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd7;
   localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd8;
   localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd9;
   localparam logic [OPCODE_W-1:0] OP_SHRA = 5'd10;
   localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd11;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd12;
   localparam logic [OPCODE_W-1:0] OP_ANDI = 5'd13;
   localparam logic [OPCODE_W-1:0] OP_ORI  = 5'd14;
   localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd15;
   localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd16;
   localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd17;
   localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd18;
   localparam logic [OPCODE_W-1:0] OP_BR   = 5'd19;
   localparam logic [OPCODE_W-1:0] OP_JR   = 5'd20;
   localparam logic [OPCODE_W-1:0] OP_JAL  = 5'd21;
   localparam logic [OPCODE_W-1:0] OP_IN   = 5'd22;
   localparam logic [OPCODE_W-1:0] OP_OUT  = 5'd23;
   localparam logic [OPCODE_W-1:0] OP_MFLO = 5'd24;
   localparam logic [OPCODE_W-1:0] OP_MFHI = 5'd25;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'd26;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'd27;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_ROR  = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_ROL  = 4'd5;
   localparam logic [ALUOP_W-1:0] ALU_SHR  = 4'd6;
   localparam logic [ALUOP_W-1:0] ALU_SHRA = 4'd7;
   localparam logic [ALUOP_W-1:0] ALU_SHL  = 4'd8;
   localparam logic [ALUOP_W-1:0] ALU_MUL  = 4'd9;
   localparam logic [ALUOP_W-1:0] ALU_DIV  = 4'd10;
   localparam logic [ALUOP_W-1:0] ALU_NEG  = 4'd11;
   localparam logic [ALUOP_W-1:0] ALU_NOT  = 4'd12;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      CLS_LOAD, CLS_LOADI, CLS_STORE, CLS_ALU_R, CLS_ALU_I, CLS_MULDIV, CLS_UNARY,
      CLS_BRANCH, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFLO, CLS_MFHI, CLS_NOP, CLS_HALT
   } op_class_e;

   typedef struct packed {
      logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outport_in;
      logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out, y_out, ba_out;
      logic gra, grb, grc, r_in, r_out;
      logic read, write, inc_pc;
      logic [ALUOP_W-1:0] alu_op;
      logic run;
   } ctrl_word_t;

   // Final execute state of each class; the sequencer returns to T0 after it.
   function automatic state_e last_exec_state(op_class_e cls);
      state_e st;
      case (cls)
         CLS_LOAD, CLS_STORE:                st = ST_T7;
         CLS_LOADI, CLS_ALU_R, CLS_ALU_I:    st = ST_T5;
         CLS_MULDIV, CLS_BRANCH:             st = ST_T6;
         CLS_UNARY, CLS_JAL:                 st = ST_T4;
         default:                            st = ST_T3;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: IR/CON in, control strobes out.
interface control_unit_if;
   import cpu_ctrl_pkg::*;

   logic [IR_W-1:0]    IR;
   logic               CON;
   logic               HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
   logic               HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout;
   logic               Gra, Grb, Grc, Rin, Rout;
   logic               Read, write, IncPC;
   logic [ALUOP_W-1:0] ALUop;
   logic               Run;

   modport master (
      input  IR, CON,
      output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
      output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout,
      output Gra, Grb, Grc, Rin, Rout, Read, write, IncPC, ALUop, Run
   );

   modport slave (
      output IR, CON,
      input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
      input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout,
      input  Gra, Grb, Grc, Rin, Rout, Read, write, IncPC, ALUop, Run
   );
endinterface

// File: rtl/op_class_decode.sv
// Combinational opcode decode into an instruction class and its ALU function.
module op_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_e           op_class_o,
   output logic [ALUOP_W-1:0]  alu_op_o
);

   always_comb begin
      op_class_o = CLS_NOP;
      alu_op_o   = ALU_ADD;
      case (opcode_i)
         OP_LD:   op_class_o = CLS_LOAD;
         OP_LDI:  op_class_o = CLS_LOADI;
         OP_ST:   op_class_o = CLS_STORE;
         OP_ADD:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_ADD;  end
         OP_SUB:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_SUB;  end
         OP_AND:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_AND;  end
         OP_OR:   begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_OR;   end
         OP_ROR:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_ROR;  end
         OP_ROL:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_ROL;  end
         OP_SHR:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_SHR;  end
         OP_SHRA: begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_SHRA; end
         OP_SHL:  begin op_class_o = CLS_ALU_R;  alu_op_o = ALU_SHL;  end
         OP_ADDI: begin op_class_o = CLS_ALU_I;  alu_op_o = ALU_ADD;  end
         OP_ANDI: begin op_class_o = CLS_ALU_I;  alu_op_o = ALU_AND;  end
         OP_ORI:  begin op_class_o = CLS_ALU_I;  alu_op_o = ALU_OR;   end
         OP_DIV:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_DIV;  end
         OP_MUL:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_MUL;  end
         OP_NEG:  begin op_class_o = CLS_UNARY;  alu_op_o = ALU_NEG;  end
         OP_NOT:  begin op_class_o = CLS_UNARY;  alu_op_o = ALU_NOT;  end
         OP_BR:   op_class_o = CLS_BRANCH;
         OP_JR:   op_class_o = CLS_JR;
         OP_JAL:  op_class_o = CLS_JAL;
         OP_IN:   op_class_o = CLS_IN;
         OP_OUT:  op_class_o = CLS_OUT;
         OP_MFLO: op_class_o = CLS_MFLO;
         OP_MFHI: op_class_o = CLS_MFHI;
         OP_NOP:  op_class_o = CLS_NOP;
         OP_HALT: op_class_o = CLS_HALT;
         default: op_class_o = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Mini SRC multi-cycle sequencer: fetch T0-T2, class-specific execute T3-T7,
// with a Moore control word decoded from state, opcode class and CON.
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   control_unit_if.master cu_bus
);

   state_e             state_q, state_d;
   op_class_e          op_class;
   logic [ALUOP_W-1:0] alu_op;
   ctrl_word_t         cw;

   op_class_decode u_op_class_decode (
      .opcode_i   (cu_bus.IR[IR_W-1:OPCODE_LSB]),
      .op_class_o (op_class),
      .alu_op_o   (alu_op)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      cw      = '0;
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_T0: begin
            cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1; cw.z_in = 1'b1;
            state_d = ST_T1;
         end
         ST_T1: begin
            cw.zlo_out = 1'b1; cw.pc_in = 1'b1; cw.read = 1'b1; cw.mdr_in = 1'b1;
            state_d = ST_T2;
         end
         ST_T2: begin
            cw.mdr_out = 1'b1; cw.ir_in = 1'b1;
            // IR is being presented while IRin is high, so nop/halt resolve here.
            if (op_class == CLS_NOP)       state_d = ST_T0;
            else if (op_class == CLS_HALT) state_d = ST_HALT;
            else                           state_d = ST_T3;
         end
         ST_T3:   state_d = ST_T4;
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_T7;
         ST_T7:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RESET;
      endcase

      cw.run = (state_q != ST_RESET) && (state_q != ST_HALT);

      if (state_q inside {ST_T3, ST_T4, ST_T5, ST_T6, ST_T7}) begin
         if (state_q == last_exec_state(op_class)) state_d = ST_T0;
         case (op_class)
            CLS_LOAD, CLS_LOADI, CLS_STORE: begin
               case (state_q)
                  ST_T3: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
                  ST_T4: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = ALU_ADD; end
                  ST_T5: begin
                     cw.zlo_out = 1'b1;
                     if (op_class == CLS_LOADI) begin cw.gra = 1'b1; cw.r_in = 1'b1; end
                     else                       cw.mar_in = 1'b1;
                  end
                  ST_T6: begin
                     cw.mdr_in = 1'b1;
                     if (op_class == CLS_LOAD) cw.read = 1'b1;
                     else begin cw.gra = 1'b1; cw.r_out = 1'b1; end
                  end
                  ST_T7: begin
                     if (op_class == CLS_LOAD) begin
                        cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
                     end else cw.write = 1'b1;
                  end
                  default: ;
               endcase
            end
            CLS_ALU_R, CLS_ALU_I: begin
               case (state_q)
                  ST_T3: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
                  ST_T4: begin
                     if (op_class == CLS_ALU_R) begin cw.grc = 1'b1; cw.r_out = 1'b1; end
                     else                       cw.c_out = 1'b1;
                     cw.z_in = 1'b1; cw.alu_op = alu_op;
                  end
                  ST_T5: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                  default: ;
               endcase
            end
            CLS_MULDIV: begin
               case (state_q)
                  ST_T3: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
                  ST_T4: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = alu_op; end
                  ST_T5: begin cw.zlo_out = 1'b1; cw.lo_in = 1'b1; end
                  ST_T6: begin cw.zhi_out = 1'b1; cw.hi_in = 1'b1; end
                  default: ;
               endcase
            end
            CLS_UNARY: begin
               if (state_q == ST_T3) begin
                  cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = alu_op;
               end else if (state_q == ST_T4) begin
                  cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
               end
            end
            CLS_BRANCH: begin
               case (state_q)
                  ST_T3: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_in = 1'b1; end
                  ST_T4: begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
                  ST_T5: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = ALU_ADD; end
                  ST_T6: begin cw.zlo_out = 1'b1; cw.pc_in = cu_bus.CON; end
                  default: ;
               endcase
            end
            CLS_JR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_in = 1'b1; end
            CLS_JAL: begin
               if (state_q == ST_T3) begin cw.pc_out = 1'b1; cw.grb = 1'b1; cw.r_in = 1'b1; end
               else begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_in = 1'b1; end
            end
            CLS_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
            CLS_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.outport_in = 1'b1; end
            CLS_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
            CLS_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
            default: ;
         endcase
      end
   end

   assign cu_bus.HIin      = cw.hi_in;
   assign cu_bus.LOin      = cw.lo_in;
   assign cu_bus.PCin      = cw.pc_in;
   assign cu_bus.MDRin     = cw.mdr_in;
   assign cu_bus.Zin       = cw.z_in;
   assign cu_bus.Yin       = cw.y_in;
   assign cu_bus.MARin     = cw.mar_in;
   assign cu_bus.IRin      = cw.ir_in;
   assign cu_bus.CONin     = cw.con_in;
   assign cu_bus.OUTPORTin = cw.outport_in;
   assign cu_bus.HIout     = cw.hi_out;
   assign cu_bus.LOout     = cw.lo_out;
   assign cu_bus.ZHIout    = cw.zhi_out;
   assign cu_bus.ZLOout    = cw.zlo_out;
   assign cu_bus.PCout     = cw.pc_out;
   assign cu_bus.MDRout    = cw.mdr_out;
   assign cu_bus.INPORTout = cw.inport_out;
   assign cu_bus.Cout      = cw.c_out;
   assign cu_bus.Yout      = cw.y_out;
   assign cu_bus.BAout     = cw.ba_out;
   assign cu_bus.Gra       = cw.gra;
   assign cu_bus.Grb       = cw.grb;
   assign cu_bus.Grc       = cw.grc;
   assign cu_bus.Rin       = cw.r_in;
   assign cu_bus.Rout      = cw.r_out;
   assign cu_bus.Read      = cw.read;
   assign cu_bus.write     = cw.write;
   assign cu_bus.IncPC     = cw.inc_pc;
   assign cu_bus.ALUop     = cw.alu_op;
   assign cu_bus.Run       = cw.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed walk through the fetch/execute sequences,
// then random instruction streams checked every cycle against a step-count model.
module tb_control_unit;
   import cpu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   control_unit_if bus();

   control_unit dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .cu_bus (bus.master)
   );

   localparam logic [27:0] M_HIin      = 28'b1 << 0;
   localparam logic [27:0] M_LOin      = 28'b1 << 1;
   localparam logic [27:0] M_PCin      = 28'b1 << 2;
   localparam logic [27:0] M_MDRin     = 28'b1 << 3;
   localparam logic [27:0] M_Zin       = 28'b1 << 4;
   localparam logic [27:0] M_Yin       = 28'b1 << 5;
   localparam logic [27:0] M_MARin     = 28'b1 << 6;
   localparam logic [27:0] M_IRin      = 28'b1 << 7;
   localparam logic [27:0] M_CONin     = 28'b1 << 8;
   localparam logic [27:0] M_OUTPORTin = 28'b1 << 9;
   localparam logic [27:0] M_HIout     = 28'b1 << 10;
   localparam logic [27:0] M_LOout     = 28'b1 << 11;
   localparam logic [27:0] M_ZHIout    = 28'b1 << 12;
   localparam logic [27:0] M_ZLOout    = 28'b1 << 13;
   localparam logic [27:0] M_PCout     = 28'b1 << 14;
   localparam logic [27:0] M_MDRout    = 28'b1 << 15;
   localparam logic [27:0] M_INPORTout = 28'b1 << 16;
   localparam logic [27:0] M_Cout      = 28'b1 << 17;
   localparam logic [27:0] M_BAout     = 28'b1 << 19;
   localparam logic [27:0] M_Gra       = 28'b1 << 20;
   localparam logic [27:0] M_Grb       = 28'b1 << 21;
   localparam logic [27:0] M_Grc       = 28'b1 << 22;
   localparam logic [27:0] M_Rin       = 28'b1 << 23;
   localparam logic [27:0] M_Rout      = 28'b1 << 24;
   localparam logic [27:0] M_Read      = 28'b1 << 25;
   localparam logic [27:0] M_write     = 28'b1 << 26;
   localparam logic [27:0] M_IncPC     = 28'b1 << 27;

   localparam logic [27:0] FETCH0 = M_PCout | M_MARin | M_IncPC | M_Zin;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   // {Run, ALUop, strobes}
   logic [32:0] dut_word;
   assign dut_word = {bus.Run, bus.ALUop,
                      bus.IncPC, bus.write, bus.Read, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                      bus.BAout, bus.Yout, bus.Cout, bus.INPORTout, bus.MDRout, bus.PCout,
                      bus.ZLOout, bus.ZHIout, bus.LOout, bus.HIout, bus.OUTPORTin, bus.CONin,
                      bus.IRin, bus.MARin, bus.Yin, bus.Zin, bus.MDRin, bus.PCin, bus.LOin, bus.HIin};

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h (IR %h CON %b t=%0t)", name, act, exp, bus.IR, bus.CON, $time);
      end
   endtask

   // Model: mode 0 = reset, 1 = running, 2 = halted; step counts cycles into the instruction.
   int m_mode = 0;
   int m_step = 0;

   function automatic int instr_len(int op);
      case (op)
         0, 2:      return 8;
         15, 16, 19: return 7;
         17, 18, 21: return 5;
         20, 22, 23, 24, 25: return 4;
         26, 27, 28, 29, 30, 31: return 3;
         default:   return 6;
      endcase
   endfunction

   function automatic logic [32:0] model_word(int mode, int step, int op, logic con);
      logic [27:0] m;
      logic [3:0]  alu;
      int          e;
      m = '0; alu = 4'd0; e = step - 3;
      if (mode != 1) return 33'd0;
      if (step == 0)      m = FETCH0;
      else if (step == 1) m = M_ZLOout | M_PCin | M_Read | M_MDRin;
      else if (step == 2) m = M_MDRout | M_IRin;
      else if (op <= 2) begin
         case (e)
            0: m = M_Grb | M_BAout | M_Yin;
            1: m = M_Cout | M_Zin;
            2: m = (op == 1) ? (M_ZLOout | M_Gra | M_Rin) : (M_ZLOout | M_MARin);
            3: m = (op == 0) ? (M_Read | M_MDRin) : (M_Gra | M_Rout | M_MDRin);
            4: m = (op == 0) ? (M_MDRout | M_Gra | M_Rin) : M_write;
            default: m = '0;
         endcase
      end else if (op <= 14) begin
         case (e)
            0: m = M_Grb | M_Rout | M_Yin;
            1: begin
               m = (op <= 11) ? (M_Grc | M_Rout | M_Zin) : (M_Cout | M_Zin);
               if (op <= 11)       alu = 4'(op - 3);
               else if (op == 13)  alu = 4'd2;
               else if (op == 14)  alu = 4'd3;
            end
            2: m = M_ZLOout | M_Gra | M_Rin;
            default: m = '0;
         endcase
      end else if (op <= 16) begin
         case (e)
            0: m = M_Gra | M_Rout | M_Yin;
            1: begin m = M_Grb | M_Rout | M_Zin; alu = (op == 16) ? 4'd9 : 4'd10; end
            2: m = M_ZLOout | M_LOin;
            3: m = M_ZHIout | M_HIin;
            default: m = '0;
         endcase
      end else if (op <= 18) begin
         if (e == 0) begin m = M_Grb | M_Rout | M_Zin; alu = (op == 17) ? 4'd11 : 4'd12; end
         else m = M_ZLOout | M_Gra | M_Rin;
      end else begin
         case (op)
            19: case (e)
                   0: m = M_Gra | M_Rout | M_CONin;
                   1: m = M_PCout | M_Yin;
                   2: m = M_Cout | M_Zin;
                   default: m = M_ZLOout | (con ? M_PCin : 28'd0);
                endcase
            20: m = M_Gra | M_Rout | M_PCin;
            21: m = (e == 0) ? (M_PCout | M_Grb | M_Rin) : (M_Gra | M_Rout | M_PCin);
            22: m = M_INPORTout | M_Gra | M_Rin;
            23: m = M_Gra | M_Rout | M_OUTPORTin;
            24: m = M_LOout | M_Gra | M_Rin;
            25: m = M_HIout | M_Gra | M_Rin;
            default: m = '0;
         endcase
      end
      return {1'b1, alu, m};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode <= 0; m_step <= 0;
      end else if (m_mode == 0) begin
         m_mode <= 1; m_step <= 0;
      end else if (m_mode == 1) begin
         if (m_step == 2 && int'(bus.IR[31:27]) == 27) m_mode <= 2;
         else if (m_step + 1 >= instr_len(int'(bus.IR[31:27]))) m_step <= 0;
         else m_step <= m_step + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en)
         check("cycle", dut_word, model_word(m_mode, m_step, int'(bus.IR[31:27]), bus.CON));
   end

   // Directed instructions first ({CON, IR}); random ones afterwards.
   logic [32:0] ir_q[$];

   task automatic drive();
      logic [32:0] v;
      if (m_mode == 1 && m_step == 2) begin
         if (ir_q.size() > 0) v = ir_q.pop_front();
         else v = {1'($urandom_range(0, 1)), 32'($urandom())};
         bus.CON = v[32];
         bus.IR  = v[31:0];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
   endtask

   int halt_cnt = 0;

   initial begin
      bus.IR  = 32'h0;
      bus.CON = 1'b0;
      ir_q.push_back({1'b0, 32'h19890000});   // add R3,R1,R2
      ir_q.push_back({1'b1, 32'h98000000});   // br, CON=1
      ir_q.push_back({1'b0, 32'h98000000});   // br, CON=0
      ir_q.push_back({1'b0, 32'h10000000});   // st
      ir_q.push_back({1'b0, 32'h00000000});   // ld
      ir_q.push_back({1'b0, 32'hD8000000});   // halt

      rst = 1'b1;
      cyc();
      chk_en = 1'b1;
      cyc();
      check("reset_zero", dut_word, 33'd0);

      rst = 1'b0;
      cyc(); check("fetch_T0", dut_word, {1'b1, 4'd0, FETCH0});
      cyc(); check("fetch_T1", dut_word, {1'b1, 4'd0, M_ZLOout | M_PCin | M_Read | M_MDRin});
      cyc(); check("fetch_T2", dut_word, {1'b1, 4'd0, M_MDRout | M_IRin});
      cyc(); check("add_T3", dut_word, {1'b1, 4'd0, M_Grb | M_Rout | M_Yin});
      cyc(); check("add_T4", dut_word, {1'b1, 4'd0, M_Grc | M_Rout | M_Zin});
      cyc(); check("add_T5", dut_word, {1'b1, 4'd0, M_ZLOout | M_Gra | M_Rin});
      cyc(); check("add_back_T0", dut_word, {1'b1, 4'd0, FETCH0});

      repeat (6) cyc();
      check("br_con1_T6", dut_word, {1'b1, 4'd0, M_ZLOout | M_PCin});
      cyc();
      repeat (6) cyc();
      check("br_con0_T6", dut_word, {1'b1, 4'd0, M_ZLOout});
      cyc();

      repeat (6) cyc();
      check("st_T6", dut_word, {1'b1, 4'd0, M_Gra | M_Rout | M_MDRin});
      cyc(); check("st_T7", dut_word, {1'b1, 4'd0, M_write});
      cyc(); check("st_back_T0", dut_word, {1'b1, 4'd0, FETCH0});

      repeat (5) cyc();
      check("ld_T5", dut_word, {1'b1, 4'd0, M_ZLOout | M_MARin});
      rst = 1'b1;
      cyc(); check("ld_reset", dut_word, 33'd0);
      rst = 1'b0;
      cyc(); check("ld_reset_T0", dut_word, {1'b1, 4'd0, FETCH0});

      cyc(); cyc();
      for (int i = 0; i < 20; i++) begin
         cyc();
         check("halt_idle", dut_word, 33'd0);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc(); check("halt_release_T0", dut_word, {1'b1, 4'd0, FETCH0});

      for (int i = 0; i < 4000; i++) begin
         halt_cnt = (m_mode == 2) ? halt_cnt + 1 : 0;
         rst = (halt_cnt >= 3) || ($urandom_range(0, 299) == 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
